lfsr_247: RTL and testbench

LFSR_247 -- requirements
Module: lfsr_247

---
 rtl/lfsr_247.sv | 52 +++++
 tb/tb_lfsr_247.sv | 100 ++++++++++
 2 files changed

// File: rtl/lfsr_247.sv
// lfsr_247: 247-bit Fibonacci BIST LFSR (x^247 + x^82 + 1) with seed-on-first-enable and two scan test flops.
module lfsr_247_flop_r0 (
  output logic q,
  input  logic clk,
  input  logic d,
  input  logic rst_l
);
  always_ff @(posedge clk) q <= rst_l ? 1'b0 : d;
endmodule

module lfsr_247_flop_r1 (
  output logic q,
  input  logic clk,
  input  logic d,
  input  logic rst_l
);
  always_ff @(posedge clk) q <= rst_l ? 1'b1 : d;
endmodule

module lfsr_247 #(
  parameter int              LEN  = 247,
  parameter int              TAP  = 81,
  parameter logic [LEN-1:0]  SEED = 247'h1
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           bist_en,
  input  logic           tdata,
  output logic [LEN-1:0] value,
  output logic           q0,
  output logic           q1
);
  logic [LEN-1:0] value_q, value_d;
  logic           init_bist, init_bist_d;
  // The first enabled cycle after reset loads SEED instead of shifting.
  always_comb begin
    value_d     = bist_en ? (init_bist ? SEED : {value_q[LEN-2:0], value_q[LEN-1] ^ value_q[TAP]}) : value_q;
    init_bist_d = init_bist & ~bist_en;
  end
  always_ff @(posedge clk) begin
    if (rst_l) begin
      value_q   <= '0;
      init_bist <= 1'b1;
    end else begin
      value_q   <= value_d;
      init_bist <= init_bist_d;
    end
  end
  assign value = value_q;
  lfsr_247_flop_r0 u_q0 (.q(q0), .clk(clk), .d(tdata), .rst_l(rst_l));
  lfsr_247_flop_r1 u_q1 (.q(q1), .clk(clk), .d(tdata), .rst_l(rst_l));
endmodule

// File: tb/tb_lfsr_247.sv
// tb_lfsr_247: scoreboard bench for lfsr_247 against an independent reference LFSR model.
module tb_lfsr_247;
  logic         clk = 1'b0;
  logic         rst_l, bist_en, tdata;
  logic [246:0] value;
  logic         q0, q1;
  always #5 clk = ~clk;
  lfsr_247 dut (.clk(clk), .rst_l(rst_l), .bist_en(bist_en), .tdata(tdata), .value(value), .q0(q0), .q1(q1));
  typedef struct packed {
    logic [246:0] v;
    logic         i;
    logic         a;
    logic         b;
  } exp_t;
  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [246:0] m_v;
  logic         m_i, m_a, m_b;
  function automatic logic [246:0] lfsr_next(input logic [246:0] v);
    logic fb;
    fb = v[246] ^ v[81];
    return (v << 1) | {246'b0, fb};
  endfunction
  task automatic chk(input string tag, input logic [246:0] got, input logic [246:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic b, input logic t);
    exp_t e;
    @(negedge clk);
    rst_l = r;
    bist_en = b;
    tdata = t;
    if (r) begin
      m_v = '0; m_i = 1'b1; m_a = 1'b0; m_b = 1'b1;
    end else begin
      m_a = t; m_b = t;
      if (b) begin
        if (m_i) begin
          m_v = 247'h1; m_i = 1'b0;
        end else m_v = lfsr_next(m_v);
      end
    end
    e.v = m_v; e.i = m_i; e.a = m_a; e.b = m_b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("value", value, e.v);
    chk("init_bist", {246'b0, dut.init_bist}, {246'b0, e.i});
    chk("q0", {246'b0, q0}, {246'b0, e.a});
    chk("q1", {246'b0, q1}, {246'b0, e.b});
  endtask
  initial begin
    logic [246:0] one, held;
    int zeros;
    one = 247'h1;
    zeros = 0;
    rst_l = 1'b1; bist_en = 1'b0; tdata = 1'b1;
    m_v = '0; m_i = 1'b1; m_a = 1'b0; m_b = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    chk("rst_value", value, '0);
    step(1'b0, 1'b0, 1'b1);
    chk("q0_one", {246'b0, q0}, 247'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("q1_zero", {246'b0, q1}, 247'h0);
    chk("value_idle", value, '0);
    step(1'b0, 1'b1, 1'b0);
    chk("seed", value, one);
    step(1'b0, 1'b1, 1'b1);
    chk("shift1", value, one << 1);
    for (int i = 2; i <= 81; i++) step(1'b0, 1'b1, i[0]);
    chk("bit81", value, one << 81);
    step(1'b0, 1'b1, 1'b0);
    chk("tap81", value, (one << 82) | one);
    for (int i = 83; i <= 247; i++) step(1'b0, 1'b1, i[1]);
    held = m_v;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, i[0]);
    chk("hold", value, held);
    step(1'b0, 1'b1, 1'b1);
    chk("resume", value, lfsr_next(held));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_rst_value", value, '0);
    chk("mid_rst_q1", {246'b0, q1}, 247'h1);
    step(1'b0, 1'b1, 1'b0);
    chk("reseed", value, one);
    for (int i = 0; i < 50000; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(1)));
      if (value == '0) zeros++;
    end
    chk("never_zero", 247'(zeros), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
